spi_write_scheduler: RTL and testbench

Controller-side SPI master that configures the on-chip SPI register peripheral (enable/PWM-enable/duty-cycle registers). It arbitrates register-write requests from two on-chip requesters (A, B) with round-robin priority and buffers them in a small command FIFO. It then serializes each command as a 16-bit write frame on SCLK/COPI/nCS. Address range checking is done here, so only legal writes reach the bus.

---
 rtl/spi_write_scheduler.sv | 139 +++++++++++++
 tb/tb_spi_write_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_write_scheduler.sv
// Two-requester round-robin register-write scheduler feeding a small command FIFO,
// serialized as 16-bit {write, addr, data} SPI frames on SCLK/COPI/nCS.
module spi_write_scheduler #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_ADDR   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        a_valid,
    output logic                        a_ready,
    input  logic [6:0]                  a_addr,
    input  logic [7:0]                  a_data,
    input  logic                        b_valid,
    output logic                        b_ready,
    input  logic [6:0]                  b_addr,
    input  logic [7:0]                  b_data,
    output logic                        SCLK,
    output logic                        COPI,
    output logic                        nCS,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        done,
    output logic                        err_addr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [6:0]  MAX_A    = 7'(MAX_ADDR);

    typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, GAP} state_t;

    state_t        state, next_state;
    logic [7:0]    div;
    logic [3:0]    bit_cnt;
    logic [14:0]   sr;
    logic [14:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic          prio, full, empty;
    logic          a_hs, b_hs, hs, legal, push, pop, phase_end;
    logic [6:0]    req_addr;
    logic [7:0]    req_data;

    // Handshake: a transfer happens on a rising clk edge where valid && ready;
    // ready is combinational and never both high while both requesters are valid.
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign a_ready  = !full && (!b_valid || !prio);
    assign b_ready  = !full && (!a_valid || prio);
    assign a_hs     = a_valid && a_ready;
    assign b_hs     = b_valid && b_ready;
    assign hs       = a_hs || b_hs;
    assign req_addr = a_hs ? a_addr : b_addr;
    assign req_data = a_hs ? a_data : b_data;
    assign legal    = (req_addr <= MAX_A);
    assign push     = hs && legal;
    assign pop      = (state == IDLE) && !empty;
    assign phase_end = (state == GAP) ? (div == GAP_LAST) : (div == DIV_LAST);
    assign fifo_count = count;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop) next_state = SETUP;
            SETUP:   if (phase_end) next_state = SCLK_HI;
            SCLK_HI: if (phase_end) next_state = SCLK_LO;
            SCLK_LO: if (phase_end) next_state = (bit_cnt == 4'd0) ? GAP : SCLK_HI;
            GAP:     if (phase_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= {req_addr, req_data};
    end

    // Pin outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            div      <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            prio     <= 1'b0;
            SCLK     <= 1'b0;
            COPI     <= 1'b0;
            nCS      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_addr <= 1'b0;
        end else begin
            state <= next_state;
            div   <= (next_state != state) ? '0 : div + 1'b1;
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (a_hs) prio <= 1'b1;
            else if (b_hs) prio <= 1'b0;

            if (pop) begin
                sr      <= mem[rd_ptr];
                bit_cnt <= 4'd15;
                rd_ptr  <= rd_ptr + 1'b1;
            end else if (state == SCLK_LO && phase_end && bit_cnt != 4'd0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end

            // The write bit leads; each SCLK_LO entry presents the next bit of sr.
            if (pop) begin
                COPI <= 1'b1;
            end else if (state == SCLK_HI && phase_end) begin
                COPI <= sr[14];
                sr   <= {sr[13:0], 1'b0};
            end else if (next_state == GAP) begin
                COPI <= 1'b0;
            end

            nCS      <= !(next_state inside {SETUP, SCLK_HI, SCLK_LO});
            SCLK     <= (next_state == SCLK_HI);
            busy     <= (next_state != IDLE) || (count_next != '0);
            done     <= (state == GAP) && phase_end;
            err_addr <= hs && !legal;
        end
    end
endmodule

// File: tb/tb_spi_write_scheduler.sv
// Bench for spi_write_scheduler: frame-position reference model checked every cycle,
// plus directed scenarios with hand-derived literal expectations.
module tb_spi_write_scheduler;
    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_ADDR   = 4;
    localparam int FRAME      = 33 * CLK_DIV;
    localparam int TOTAL      = FRAME + GAP_CYCLES;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [6:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_data = '0, b_data = '0;
    logic       a_ready, b_ready, SCLK, COPI, nCS, busy, done, err_addr;
    logic [2:0] fifo_count;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    spi_write_scheduler #(
        .CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES), .FIFO_DEPTH(FIFO_DEPTH), .MAX_ADDR(MAX_ADDR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .SCLK(SCLK), .COPI(COPI), .nCS(nCS), .busy(busy), .fifo_count(fifo_count),
        .done(done), .err_addr(err_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted commands in a queue, the active frame as a position count.
    logic [14:0] q_m[$];
    int          pos_m = -1;
    logic [15:0] cur_m = '0;
    logic        prio_m = 1'b0;
    logic        e_sclk = 1'b0, e_copi = 1'b0, e_ncs = 1'b1, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    int          e_count = 0;
    bit          model_valid = 1'b0;
    logic        m_ahs, m_bhs, m_full;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;

    function automatic void wave(input int pos, input logic [15:0] w,
                                 output logic ncs, output logic sclk, output logic copi);
        int p;
        ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        if (pos >= 0 && pos < FRAME) begin
            ncs = 1'b0;
            if (pos < CLK_DIV) begin
                copi = w[15];
            end else begin
                p = (pos - CLK_DIV) / CLK_DIV;
                if (p % 2 == 0) begin
                    sclk = 1'b1;
                    copi = w[15 - p / 2];
                end else if (p / 2 < 15) begin
                    copi = w[14 - p / 2];
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            q_m.delete();
            pos_m = -1; prio_m = 1'b0; e_done = 1'b0; e_err = 1'b0;
            model_valid = 1'b1;
        end else begin
            m_full = (q_m.size() >= FIFO_DEPTH);
            m_ahs  = a_valid && !m_full && (!b_valid || !prio_m);
            m_bhs  = b_valid && !m_full && (!a_valid || prio_m);
            e_done = 1'b0;
            if (pos_m >= 0) begin
                pos_m++;
                if (pos_m == TOTAL) begin
                    pos_m = -1;
                    e_done = 1'b1;
                end
            end else if (q_m.size() != 0) begin
                cur_m = {1'b1, q_m.pop_front()};
                pos_m = 0;
            end
            e_err = 1'b0;
            if (m_ahs || m_bhs) begin
                m_addr = m_ahs ? a_addr : b_addr;
                m_data = m_ahs ? a_data : b_data;
                if (int'(m_addr) > MAX_ADDR) e_err = 1'b1;
                else q_m.push_back({m_addr, m_data});
                prio_m = m_ahs;
            end
        end
        wave(pos_m, cur_m, e_ncs, e_sclk, e_copi);
        e_count = q_m.size();
        e_busy  = (pos_m >= 0) || (q_m.size() != 0);
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("sclk", 32'(SCLK), 32'(e_sclk));
            chk("copi", 32'(COPI), 32'(e_copi));
            chk("ncs", 32'(nCS), 32'(e_ncs));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("fifo_count", 32'(fifo_count), 32'(e_count));
            chk("done", 32'(done), 32'(e_done));
            chk("err_addr", 32'(err_addr), 32'(e_err));
            chk("a_ready", 32'(a_ready), 32'((q_m.size() < FIFO_DEPTH) && (!b_valid || !prio_m)));
            chk("b_ready", 32'(b_ready), 32'((q_m.size() < FIFO_DEPTH) && (!a_valid || prio_m)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    int          fall_idx, low_cnt, rises, dones, grants, nfalls, acc, max_cnt, done_idx, acc5_idx, ncs_low;
    int          falls[4];
    logic [15:0] bits;
    logic [3:0]  order;
    logic        prev_sclk, prev_ncs, saw_full, ga, gb;

    initial begin
        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_sclk", 32'(SCLK), 0);
        chk("rst_copi", 32'(COPI), 0);
        chk("rst_ncs", 32'(nCS), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err_addr), 0);
        chk("rst_a_ready", 32'(a_ready), 1);
        chk("rst_b_ready", 32'(b_ready), 1);
        cyc();

        // Single write: addr 4, data 0x80
        a_valid = 1'b1; a_addr = 7'd4; a_data = 8'h80;
        @(negedge clk);
        chk("single_a_ready", 32'(a_ready), 1);
        cyc();
        a_valid = 1'b0;
        fall_idx = -1; low_cnt = 0; rises = 0; dones = 0; bits = '0; prev_sclk = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (!nCS) begin
                low_cnt++;
                if (fall_idx < 0) fall_idx = i;
            end
            if (SCLK && !prev_sclk) begin
                rises++;
                bits = {bits[14:0], COPI};
            end
            prev_sclk = SCLK;
            if (done) dones++;
            cyc();
        end
        chk("single_ncs_fall_delay", 32'(fall_idx), 2);
        chk("single_ncs_low_cycles", 32'(low_cnt), 132);
        chk("single_sclk_rises", 32'(rises), 16);
        chk("single_frame_bits", 32'(bits), 32'h8480);
        chk("single_done_pulses", 32'(dones), 1);

        // Contention: both valid from prio 0
        do_reset();
        a_valid = 1'b1; b_valid = 1'b1;
        a_addr = 7'd1; a_data = 8'h11; b_addr = 7'd2; b_data = 8'h22;
        grants = 0; order = '0; nfalls = 0; prev_ncs = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            ga = a_valid && a_ready;
            gb = b_valid && b_ready;
            if (ga || gb) begin
                order = {order[2:0], gb};
                grants++;
            end
            if (prev_ncs && !nCS) begin
                if (nfalls < 4) falls[nfalls] = i;
                nfalls++;
            end
            prev_ncs = nCS;
            cyc();
            if (ga) a_data = a_data + 8'h01;
            if (gb) b_data = b_data + 8'h01;
            if (grants >= 4) begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
        end
        chk("cont_grants", 32'(grants), 4);
        chk("cont_order", 32'(order), 32'b0101);
        chk("cont_frames", 32'(nfalls), 4);
        for (int k = 1; k < 4; k++) chk("cont_spacing", 32'(falls[k] - falls[k-1]), 141);

        // Backpressure
        do_reset();
        a_valid = 1'b1; a_addr = 7'd3; a_data = 8'h50;
        cyc();
        a_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!nCS) break;
            cyc();
        end
        cyc();
        a_valid = 1'b1; a_data = 8'h60;
        acc = 0; max_cnt = 0; saw_full = 1'b0; done_idx = -1; acc5_idx = -1;
        for (int i = 0; i < 400 && acc < 5; i++) begin
            @(negedge clk);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (fifo_count == 3'd4 && !a_ready) saw_full = 1'b1;
            if (done && done_idx < 0) done_idx = i;
            ga = a_ready;
            if (ga) begin
                acc++;
                if (acc == 5) acc5_idx = i;
            end
            cyc();
            if (ga) a_data = a_data + 8'h01;
            if (acc == 5) a_valid = 1'b0;
        end
        chk("bp_accepted", 32'(acc), 5);
        chk("bp_max_count", 32'(max_cnt), 4);
        chk("bp_full_not_ready", 32'(saw_full), 1);
        chk("bp_fifth_after_pop", 32'(acc5_idx - done_idx), 1);

        // Invalid address from B
        do_reset();
        b_valid = 1'b1; b_addr = 7'd5; b_data = 8'h33;
        @(negedge clk);
        chk("inv_b_ready", 32'(b_ready), 1);
        cyc();
        b_valid = 1'b0;
        @(negedge clk);
        chk("inv_err_pulse", 32'(err_addr), 1);
        chk("inv_fifo_count", 32'(fifo_count), 0);
        cyc();
        @(negedge clk);
        chk("inv_err_clear", 32'(err_addr), 0);
        ncs_low = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            if (!nCS) ncs_low++;
        end
        chk("inv_no_frame", 32'(ncs_low), 0);
        cyc();

        // Reset in the middle of a frame with two commands queued
        do_reset();
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                b_valid = 1'b1; b_addr = 7'd2; b_data = 8'hB2;
            end else begin
                a_valid = 1'b1; a_addr = 7'(k); a_data = 8'hA0 + 8'(k);
            end
            cyc();
            a_valid = 1'b0; b_valid = 1'b0;
        end
        rises = 0; prev_sclk = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (SCLK && !prev_sclk) rises++;
            prev_sclk = SCLK;
            if (rises == 8) break;
            cyc();
        end
        chk("midrst_rises", 32'(rises), 8);
        chk("midrst_queued", 32'(fifo_count), 2);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ncs", 32'(nCS), 1);
        chk("midrst_sclk", 32'(SCLK), 0);
        chk("midrst_copi", 32'(COPI), 0);
        chk("midrst_fifo_count", 32'(fifo_count), 0);
        chk("midrst_busy", 32'(busy), 0);
        cyc();
        ncs_low = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!nCS) ncs_low++;
            cyc();
        end
        chk("midrst_no_frame", 32'(ncs_low), 0);

        // Push in the same cycle IDLE pops the only entry
        do_reset();
        a_valid = 1'b1; a_addr = 7'd0; a_data = 8'h01;
        cyc();
        a_data = 8'h02;
        cyc();
        a_valid = 1'b0;
        @(negedge clk);
        chk("pp_fifo_count", 32'(fifo_count), 1);
        chk("pp_ncs", 32'(nCS), 0);
        cyc();
        nfalls = 0; prev_ncs = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (prev_ncs && !nCS) nfalls++;
            prev_ncs = nCS;
            cyc();
        end
        chk("pp_second_frame", 32'(nfalls), 1);

        // Randomized traffic with occasional illegal addresses and resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            a_valid = ($urandom_range(0, 3) == 0);
            b_valid = ($urandom_range(0, 3) == 0);
            a_addr  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            b_addr  = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(5, 127)) : 7'($urandom_range(0, 4));
            a_data  = 8'($urandom);
            b_data  = 8'($urandom);
            rst_n   = ($urandom_range(0, 1499) != 0);
            cyc();
        end
        rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        repeat (20) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
